// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative N-cycle MUL / UDIV / SDIV unit for the LEGv8 datapath.
// Operands come from the register-file read ports; the result goes back through
// the write port (we3/wa3/wd3) as a one-cycle pulse in DONE.
// Optional feature macro: MULDIV_DIV0_EXC_EN. When it is defined, a divide by
// zero raises div0_exc in DONE and suppresses the write. When it is undefined,
// div0_exc is tied low and 0 is written to dst.
module muldiv_unit #(
   parameter int unsigned N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [4:0]   dst,
   output logic         busy,
   output logic         we3,
   output logic [4:0]   wa3,
   output logic [N-1:0] wd3,
   output logic         div0_exc
);

   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {OP_MUL, OP_UDIV, OP_SDIV, OP_RSV} op_t;

   state_t        state;
   op_t           op_q;
   logic [4:0]    dst_q;
   logic          neg_q;
   logic          div0_q;
   logic [CW-1:0] cnt;
   // acc: product (MUL) or partial remainder (DIV)
   // x:   multiplicand (MUL) or dividend shifting into quotient (DIV)
   // y:   multiplier (MUL) or divisor magnitude (DIV)
   logic [N-1:0]  acc, x, y;
   logic [N-1:0]  acc_nxt, x_nxt, y_nxt;
   logic [N:0]    rem_sh, sub;
   logic [N-1:0]  result;

   // One shift-add or restoring-division step, plus final result selection
   always_comb begin
      acc_nxt = acc;
      x_nxt   = x;
      y_nxt   = y;
      rem_sh  = '0;
      sub     = '0;
      if (op_q == OP_MUL) begin
         if (y[0])
            acc_nxt = acc + x;
         x_nxt = x << 1;
         y_nxt = y >> 1;
      end else begin
         rem_sh = {acc, x[N-1]};
         sub    = rem_sh - {1'b0, y};
         if (!sub[N]) begin
            acc_nxt = sub[N-1:0];
            x_nxt   = {x[N-2:0], 1'b1};
         end else begin
            acc_nxt = rem_sh[N-1:0];
            x_nxt   = {x[N-2:0], 1'b0};
         end
      end
      if (op_q == OP_MUL)
         result = acc_nxt;
      else if (div0_q)
         result = '0;
      else if (neg_q)
         result = -x_nxt;
      else
         result = x_nxt;
   end

   // Control FSM with registered writeback outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         we3    <= 1'b0;
         wa3    <= '0;
         wd3    <= '0;
         op_q   <= OP_MUL;
         dst_q  <= '0;
         neg_q  <= 1'b0;
         div0_q <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         x      <= '0;
         y      <= '0;
      end else begin
         we3 <= 1'b0;
         case (state)
            // DONE shares the accept path so that the edge ending DONE can
            // already take the next request (N+1 cycle back-to-back spacing)
            IDLE, DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (start && op != OP_RSV) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  op_q   <= op_t'(op);
                  dst_q  <= dst;
                  neg_q  <= (op == OP_SDIV) && (a[N-1] ^ b[N-1]);
                  div0_q <= (op != OP_MUL) && (b == '0);
                  cnt    <= '0;
                  acc    <= '0;
                  x      <= (op == OP_SDIV && a[N-1]) ? -a : a;
                  y      <= (op == OP_SDIV && b[N-1]) ? -b : b;
               end
            end
            RUN: begin
               acc <= acc_nxt;
               x   <= x_nxt;
               y   <= y_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  state <= DONE;
                  wa3   <= dst_q;
                  wd3   <= result;
`ifdef MULDIV_DIV0_EXC_EN
                  we3   <= (dst_q != 5'd31) && !div0_q;
`else
                  we3   <= (dst_q != 5'd31);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MULDIV_DIV0_EXC_EN
   logic exc_q;

   // Exception pulse for the DONE cycle of a divide by zero
   always_ff @(posedge clk) begin
      if (reset)
         exc_q <= 1'b0;
      else
         exc_q <= (state == RUN) && (cnt == CW'(N - 1)) && div0_q;
   end

   assign div0_exc = exc_q;
`else
   assign div0_exc = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [63:0] a, b;
   logic [4:0]  dst;
   logic        busy, we3, div0_exc;
   logic [4:0]  wa3;
   logic [63:0] wd3;

   int errors = 0;
   int checks = 0;

   muldiv_unit #(.N(64)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .dst(dst), .busy(busy), .we3(we3), .wa3(wa3), .wd3(wd3),
      .div0_exc(div0_exc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request and follow it through to the cycle after DONE
   task automatic do_op(input string tag, input logic [1:0] o, input logic [63:0] x,
                        input logic [63:0] y, input logic [4:0] d, input logic hold,
                        input logic [63:0] exp_wd, input logic exp_we, input logic exp_exc);
      int busy_cnt = 0;
      int early = 0;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y; dst = d;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (busy) busy_cnt++;
         if (we3 || div0_exc) early++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (busy) busy_cnt++;
      check({tag, "_early_pulse"}, 64'(early), 64'd0);
      check({tag, "_we3"}, 64'(we3), 64'(exp_we));
      check({tag, "_div0_exc"}, 64'(div0_exc), 64'(exp_exc));
      if (exp_we) begin
         check({tag, "_wa3"}, 64'(wa3), 64'(d));
         check({tag, "_wd3"}, wd3, exp_wd);
      end
      @(posedge clk); #1;
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd65);
      check({tag, "_idle_after"}, {62'd0, busy, we3}, 64'd0);
   endtask

   initial begin
      int cnt;
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; dst = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_we3", 64'(we3), 64'd0);
      check("reset_wa3", 64'(wa3), 64'd0);
      check("reset_wd3", wd3, 64'd0);
      check("reset_div0", 64'(div0_exc), 64'd0);
      reset = 1'b0;

      do_op("mul_7_m3", 2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1'b0,
            64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 1'b0);
      do_op("udiv_100_7", 2'b01, 64'd100, 64'd7, 5'd9, 1'b0, 64'd14, 1'b1, 1'b0);
      do_op("sdiv_m100_7", 2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd10, 1'b0,
            64'hFFFF_FFFF_FFFF_FFF2, 1'b1, 1'b0);
      do_op("sdiv_min_m1", 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            5'd11, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
      do_op("sdiv_m7_m2", 2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE,
            5'd12, 1'b0, 64'd3, 1'b1, 1'b0);
`ifdef MULDIV_DIV0_EXC_EN
      do_op("udiv_by0", 2'b01, 64'd42, 64'd0, 5'd3, 1'b0, 64'd0, 1'b0, 1'b1);
`else
      do_op("udiv_by0", 2'b01, 64'd42, 64'd0, 5'd3, 1'b0, 64'd0, 1'b1, 1'b0);
`endif
      do_op("mul_xzr", 2'b00, 64'd5, 64'd6, 5'd31, 1'b0, 64'd30, 1'b0, 1'b0);
      do_op("mul_hold", 2'b00, 64'd11, 64'd13, 5'd6, 1'b1, 64'd143, 1'b1, 1'b0);

      // Reserved op must never be accepted
      @(negedge clk);
      start = 1'b1; op = 2'b11; a = 64'd1; b = 64'd1; dst = 5'd2;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (busy || we3) cnt++;
      end
      start = 1'b0;
      check("reserved_op_ignored", 64'(cnt), 64'd0);

      // Reset at RUN iteration 30 aborts the operation silently
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 64'd9; b = 64'd9; dst = 5'd4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      cnt = 0;
      for (int i = 0; i < 70; i++) begin
         if (busy || we3 || div0_exc) cnt++;
         @(posedge clk); #1;
      end
      check("abort_no_pulse", 64'(cnt), 64'd0);
      do_op("mul_after_abort", 2'b00, 64'd2, 64'd3, 5'd7, 1'b0, 64'd6, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
